// File: rtl/mips_id_ex_if.sv
// ---------------------------------------------------------------------------
// mips_id_ex_if
// Bundle between the MIPS decode controller (ID) and the ID/EX stage.
//   id_*       : decoded control bundle and register specifiers from ID
//   flush      : taken branch/jump, kill the instruction currently in ID
//   ex_*       : registered bundle presented to EX
//   stall      : hold PC and IF/ID this cycle
//   mult_busy  : multiplier still producing Lo/Hi
// master = decode side (drives id_*, flush), slave = the ID/EX stage.
// ---------------------------------------------------------------------------
interface mips_id_ex_if;
    logic       id_valid;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_memwrite;
    logic [1:0] id_wAddSel;
    logic [1:0] id_wDataSel;
    logic [2:0] id_ALUfunc;
    logic       id_bdsel;
    logic       id_dsel;
    logic [1:0] id_IDdatasel;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       flush;

    logic       ex_valid;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_memwrite;
    logic       ex_bdsel;
    logic       ex_dsel;
    logic [1:0] ex_wDataSel;
    logic [1:0] ex_IDdatasel;
    logic [2:0] ex_ALUfunc;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_wreg;
    logic       stall;
    logic       mult_busy;

    modport master (
        output id_valid, id_regwrite, id_memread, id_memwrite, id_wAddSel,
               id_wDataSel, id_ALUfunc, id_bdsel, id_dsel, id_IDdatasel,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, flush,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_bdsel,
               ex_dsel, ex_wDataSel, ex_IDdatasel, ex_ALUfunc, ex_rs, ex_rt,
               ex_wreg, stall, mult_busy
    );

    modport slave (
        input  id_valid, id_regwrite, id_memread, id_memwrite, id_wAddSel,
               id_wDataSel, id_ALUfunc, id_bdsel, id_dsel, id_IDdatasel,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, flush,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_bdsel,
               ex_dsel, ex_wDataSel, ex_IDdatasel, ex_ALUfunc, ex_rs, ex_rt,
               ex_wreg, stall, mult_busy
    );
endinterface

// File: rtl/mips_id_ex_stage.sv
// ---------------------------------------------------------------------------
// mips_id_ex_stage
// ID/EX pipeline register for the MIPS core. Registers the decoded bundle
// into EX, detects load-use and multiplier-busy hazards (stall + bubble),
// applies branch/jump flushes and owns the MULT busy counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mips_id_ex_if.slave (id_* bundle and flush in; ex_*, stall,
//          mult_busy out)
// Parameter:
//   MULT_CYCLES : EX cycles a MULT occupies the multiplier (>=1)
// ---------------------------------------------------------------------------
module mips_id_ex_stage #(
    parameter int MULT_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    mips_id_ex_if.slave   bus
);
    localparam int CNT_W = (MULT_CYCLES < 1) ? 1 : $clog2(MULT_CYCLES + 1);
    localparam logic [2:0] FUNC_MULT = 3'b101;
    localparam logic [2:0] FUNC_MFHI = 3'b110;
    localparam logic [2:0] FUNC_MFLO = 3'b111;

    logic [CNT_W-1:0] mult_cnt_reg, mult_cnt_next;

    logic       ex_valid_reg;
    logic       ex_regwrite_reg;
    logic       ex_memread_reg;
    logic       ex_memwrite_reg;
    logic       ex_bdsel_reg;
    logic       ex_dsel_reg;
    logic [1:0] ex_wdatasel_reg;
    logic [1:0] ex_iddatasel_reg;
    logic [2:0] ex_alufunc_reg;
    logic [4:0] ex_rs_reg;
    logic [4:0] ex_rt_reg;
    logic [4:0] ex_wreg_reg;

    logic [4:0] dest_next;
    logic       load_use;
    logic       mult_haz;
    logic       mult_busy;
    logic       stall;
    logic       accept;
    logic       func_uses_mul;

    // Destination register resolved in ID so EX only sees a final number.
    always_comb begin
        dest_next = 5'd0;
        case (bus.id_wAddSel)
            2'b00:   dest_next = bus.id_rt;
            2'b01:   dest_next = bus.id_rd;
            2'b10:   dest_next = 5'd31;
            default: dest_next = 5'd0;
        endcase
    end

    assign mult_busy = (mult_cnt_reg != '0);

    // Only EX state feeds the hazard check; a bubble has regwrite/memread
    // clear, so it can never cause a further stall.
    assign load_use = ex_valid_reg & ex_memread_reg & ex_regwrite_reg &
                      (ex_wreg_reg != 5'd0) &
                      ((bus.id_uses_rs & (bus.id_rs == ex_wreg_reg)) |
                       (bus.id_uses_rt & (bus.id_rt == ex_wreg_reg)));

    assign func_uses_mul = (bus.id_ALUfunc == FUNC_MULT) |
                           (bus.id_ALUfunc == FUNC_MFHI) |
                           (bus.id_ALUfunc == FUNC_MFLO);

    // The ALU func codes 101..111 are only multiplier ops for R-type
    // encodings, which decode as writeback-from-ALU or no writeback.
    assign mult_haz = mult_busy & func_uses_mul &
                      (bus.id_dsel | ~bus.id_regwrite);

    // Flush wins over hazards: the instruction is dead so there is nothing
    // to hold. Reset forces stall low even while the counter still reads busy.
    assign stall  = ~rst & bus.id_valid & ~bus.flush & (load_use | mult_haz);
    assign accept = bus.id_valid & ~bus.flush & ~stall;

    // Flush does not touch the counter: an in-flight MULT keeps counting.
    always_comb begin
        mult_cnt_next = mult_cnt_reg;
        if (accept && (bus.id_ALUfunc == FUNC_MULT)) begin
            mult_cnt_next = CNT_W'(MULT_CYCLES);
        end else if (mult_cnt_reg != '0) begin
            mult_cnt_next = mult_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_cnt_reg <= '0;
        end else begin
            mult_cnt_reg <= mult_cnt_next;
        end
    end

    // Reset and bubble load the same all-zero bundle.
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            ex_valid_reg     <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_bdsel_reg     <= 1'b0;
            ex_dsel_reg      <= 1'b0;
            ex_wdatasel_reg  <= 2'b00;
            ex_iddatasel_reg <= 2'b00;
            ex_alufunc_reg   <= 3'b000;
            ex_rs_reg        <= 5'd0;
            ex_rt_reg        <= 5'd0;
            ex_wreg_reg      <= 5'd0;
        end else begin
            ex_valid_reg     <= 1'b1;
            ex_regwrite_reg  <= bus.id_regwrite;
            ex_memread_reg   <= bus.id_memread;
            ex_memwrite_reg  <= bus.id_memwrite;
            ex_bdsel_reg     <= bus.id_bdsel;
            ex_dsel_reg      <= bus.id_dsel;
            ex_wdatasel_reg  <= bus.id_wDataSel;
            ex_iddatasel_reg <= bus.id_IDdatasel;
            ex_alufunc_reg   <= bus.id_ALUfunc;
            ex_rs_reg        <= bus.id_rs;
            ex_rt_reg        <= bus.id_rt;
            ex_wreg_reg      <= dest_next;
        end
    end

    assign bus.ex_valid     = ex_valid_reg;
    assign bus.ex_regwrite  = ex_regwrite_reg;
    assign bus.ex_memread   = ex_memread_reg;
    assign bus.ex_memwrite  = ex_memwrite_reg;
    assign bus.ex_bdsel     = ex_bdsel_reg;
    assign bus.ex_dsel      = ex_dsel_reg;
    assign bus.ex_wDataSel  = ex_wdatasel_reg;
    assign bus.ex_IDdatasel = ex_iddatasel_reg;
    assign bus.ex_ALUfunc   = ex_alufunc_reg;
    assign bus.ex_rs        = ex_rs_reg;
    assign bus.ex_rt        = ex_rt_reg;
    assign bus.ex_wreg      = ex_wreg_reg;
    assign bus.stall        = stall;
    assign bus.mult_busy    = mult_busy;
endmodule

// File: tb/tb_mips_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_id_ex_stage
// Directed vector table (instruction sequences with hand-derived expected
// outputs) followed by randomized stimulus checked against a behavioural
// model of the ID/EX stage.
// ---------------------------------------------------------------------------
module tb_mips_id_ex_stage;
    localparam int MULT_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_id_ex_if bus();

    mips_id_ex_stage #(.MULT_CYCLES(MULT_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] wAddSel;
        logic [1:0] wDataSel;
        logic [2:0] func;
        logic       bdsel;
        logic       dsel;
        logic [1:0] IDdatasel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       uses_rs;
        logic       uses_rt;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       e_stall;
        logic       e_valid;
        logic [4:0] e_wreg;
        logic       e_rw;
        logic [2:0] e_func;
        logic       e_busy;
    } vec_t;

    // Same field order as the packed DUT snapshot below.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       bdsel;
        logic       dsel;
        logic [1:0] wDataSel;
        logic [1:0] IDdatasel;
        logic [2:0] func;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
    } exm_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: the instruction sitting in EX and the edge
    // number at which the most recent MULT entered EX.
    exm_t m_ex = '0;
    int   edge_cnt = 0;
    int   mult_edge = -1000;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic stim_t mk_nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
        stim_t s = '0;
        s.valid = 1; s.regwrite = 1; s.memread = 1; s.wAddSel = 2'b00;
        s.wDataSel = 2'b01; s.func = 3'b010; s.bdsel = 1; s.rs = rs; s.rt = rt;
        s.uses_rs = 1;
        return s;
    endfunction

    function automatic stim_t mk_rtype(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [2:0] func);
        stim_t s = '0;
        s.valid = 1; s.regwrite = 1; s.wAddSel = 2'b01; s.func = func; s.dsel = 1;
        s.rs = rs; s.rt = rt; s.rd = rd; s.uses_rs = 1; s.uses_rt = 1;
        return s;
    endfunction

    function automatic stim_t mk_addi(input logic [4:0] rt, input logic [4:0] rs);
        stim_t s = '0;
        s.valid = 1; s.regwrite = 1; s.wAddSel = 2'b00; s.func = 3'b010;
        s.bdsel = 1; s.dsel = 1; s.rs = rs; s.rt = rt; s.uses_rs = 1;
        return s;
    endfunction

    function automatic stim_t mk_mult(input logic [4:0] rs, input logic [4:0] rt);
        stim_t s = '0;
        s.valid = 1; s.regwrite = 0; s.wAddSel = 2'b01; s.func = 3'b101; s.dsel = 1;
        s.rs = rs; s.rt = rt; s.uses_rs = 1; s.uses_rt = 1;
        return s;
    endfunction

    function automatic stim_t mk_mflo(input logic [4:0] rd);
        stim_t s = '0;
        s.valid = 1; s.regwrite = 1; s.wAddSel = 2'b01; s.func = 3'b111; s.dsel = 1;
        s.rd = rd;
        return s;
    endfunction

    function automatic stim_t mk_jal();
        stim_t s = '0;
        s.valid = 1; s.regwrite = 1; s.wAddSel = 2'b10; s.wDataSel = 2'b10;
        return s;
    endfunction

    function automatic vec_t row(input stim_t s, input logic st, input logic v,
                                 input logic [4:0] w, input logic rw,
                                 input logic [2:0] f, input logic b);
        vec_t r;
        r.s = s; r.e_stall = st; r.e_valid = v; r.e_wreg = w; r.e_rw = rw;
        r.e_func = f; r.e_busy = b;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic model_busy();
        return (edge_cnt - mult_edge) < MULT_CYCLES;
    endfunction

    function automatic logic model_stall(input stim_t s);
        logic lu, mh;
        if (s.rst) return 1'b0;
        lu = m_ex.valid && m_ex.memread && m_ex.regwrite && (m_ex.wreg != 0) &&
             ((s.uses_rs && s.rs == m_ex.wreg) || (s.uses_rt && s.rt == m_ex.wreg));
        mh = model_busy() && (s.func >= 3'd5) && (s.dsel || !s.regwrite);
        return s.valid && !s.flush && (lu || mh);
    endfunction

    task automatic model_edge(input stim_t s, input logic st);
        edge_cnt++;
        if (s.rst) begin
            m_ex = '0;
            mult_edge = -1000;
        end else if (s.flush || st || !s.valid) begin
            m_ex = '0;
        end else begin
            m_ex.valid = 1; m_ex.regwrite = s.regwrite; m_ex.memread = s.memread;
            m_ex.memwrite = s.memwrite; m_ex.bdsel = s.bdsel; m_ex.dsel = s.dsel;
            m_ex.wDataSel = s.wDataSel; m_ex.IDdatasel = s.IDdatasel;
            m_ex.func = s.func; m_ex.rs = s.rs; m_ex.rt = s.rt;
            case (s.wAddSel)
                2'b00: m_ex.wreg = s.rt;
                2'b01: m_ex.wreg = s.rd;
                2'b10: m_ex.wreg = 5'd31;
                default: m_ex.wreg = 5'd0;
            endcase
            if (s.func == 3'b101) mult_edge = edge_cnt;
        end
    endtask

    function automatic exm_t dut_ex();
        exm_t d;
        d.valid = bus.ex_valid; d.regwrite = bus.ex_regwrite; d.memread = bus.ex_memread;
        d.memwrite = bus.ex_memwrite; d.bdsel = bus.ex_bdsel; d.dsel = bus.ex_dsel;
        d.wDataSel = bus.ex_wDataSel; d.IDdatasel = bus.ex_IDdatasel;
        d.func = bus.ex_ALUfunc; d.rs = bus.ex_rs; d.rt = bus.ex_rt; d.wreg = bus.ex_wreg;
        return d;
    endfunction

    // One clock: drive ID, check stall mid-cycle, check EX after the edge.
    task automatic run_cycle(input stim_t s, input bit use_tab, input vec_t v, input int idx);
        logic m_st;
        rst = s.rst;
        bus.flush = s.flush; bus.id_valid = s.valid; bus.id_regwrite = s.regwrite;
        bus.id_memread = s.memread; bus.id_memwrite = s.memwrite;
        bus.id_wAddSel = s.wAddSel; bus.id_wDataSel = s.wDataSel;
        bus.id_ALUfunc = s.func; bus.id_bdsel = s.bdsel; bus.id_dsel = s.dsel;
        bus.id_IDdatasel = s.IDdatasel; bus.id_rs = s.rs; bus.id_rt = s.rt;
        bus.id_rd = s.rd; bus.id_uses_rs = s.uses_rs; bus.id_uses_rt = s.uses_rt;
        @(negedge clk);
        m_st = model_stall(s);
        if (use_tab) begin
            chk($sformatf("row%0d stall", idx), bus.stall, v.e_stall);
        end else begin
            chk($sformatf("rnd%0d stall", idx), bus.stall, m_st);
            if (!s.rst) chk($sformatf("rnd%0d busy_pre", idx), bus.mult_busy, model_busy());
        end
        @(posedge clk);
        model_edge(s, m_st);
        #1;
        if (use_tab) begin
            chk($sformatf("row%0d ex_valid", idx), bus.ex_valid, v.e_valid);
            chk($sformatf("row%0d ex_wreg", idx), bus.ex_wreg, v.e_wreg);
            chk($sformatf("row%0d ex_regwrite", idx), bus.ex_regwrite, v.e_rw);
            chk($sformatf("row%0d ex_ALUfunc", idx), bus.ex_ALUfunc, v.e_func);
            chk($sformatf("row%0d mult_busy", idx), bus.mult_busy, v.e_busy);
        end else begin
            chk($sformatf("rnd%0d ex_bundle", idx), dut_ex(), m_ex);
            chk($sformatf("rnd%0d mult_busy", idx), bus.mult_busy, model_busy());
        end
        $display("%s %0d: rst=%0b flush=%0b id_valid=%0b func=%0d stall=%0b ex_valid=%0b ex_wreg=%0d ex_func=%0d busy=%0b",
                 use_tab ? "vec" : "rnd", idx, s.rst, s.flush, s.valid, s.func,
                 m_st, bus.ex_valid, bus.ex_wreg, bus.ex_ALUfunc, bus.mult_busy);
    endtask

    vec_t vecs[$];

    initial begin
        stim_t s;
        vec_t  dummy = '0;

        // reset with a real instruction on ID: must be ignored
        s = mk_lw(5'd5, 5'd2); s.rst = 1;
        vecs.push_back(row(s, 0, 0, 5'd0, 0, 3'b000, 0));
        // load-use on rs: one stall + bubble, then the add enters EX
        vecs.push_back(row(mk_lw(5'd5, 5'd2),             0, 1, 5'd5, 1, 3'b010, 0));
        vecs.push_back(row(mk_rtype(5'd6, 5'd5, 5'd1, 3'b010), 1, 0, 5'd0, 0, 3'b000, 0));
        vecs.push_back(row(mk_rtype(5'd6, 5'd5, 5'd1, 3'b010), 0, 1, 5'd6, 1, 3'b010, 0));
        // load to r0 is hazard-free
        vecs.push_back(row(mk_lw(5'd0, 5'd3),             0, 1, 5'd0, 1, 3'b010, 0));
        vecs.push_back(row(mk_rtype(5'd7, 5'd0, 5'd0, 3'b010), 0, 1, 5'd7, 1, 3'b010, 0));
        // addi writing the loaded register without reading it
        vecs.push_back(row(mk_lw(5'd5, 5'd2),             0, 1, 5'd5, 1, 3'b010, 0));
        vecs.push_back(row(mk_addi(5'd5, 5'd1),           0, 1, 5'd5, 1, 3'b010, 0));
        // flush beats a load-use hazard
        vecs.push_back(row(mk_lw(5'd5, 5'd2),             0, 1, 5'd5, 1, 3'b010, 0));
        s = mk_rtype(5'd6, 5'd5, 5'd1, 3'b010); s.flush = 1;
        vecs.push_back(row(s,                             0, 0, 5'd0, 0, 3'b000, 0));
        // jal -> r31, wAddSel=11 -> r0, then an empty ID slot
        vecs.push_back(row(mk_jal(),                      0, 1, 5'd31, 1, 3'b000, 0));
        s = mk_rtype(5'd9, 5'd1, 5'd2, 3'b010); s.wAddSel = 2'b11;
        vecs.push_back(row(s,                             0, 1, 5'd0, 1, 3'b010, 0));
        vecs.push_back(row(mk_nop(),                      0, 0, 5'd0, 0, 3'b000, 0));
        // MULT then MFLO back-to-back: four stall cycles, MFLO enters on the fifth
        vecs.push_back(row(mk_mult(5'd1, 5'd2),           0, 1, 5'd0, 0, 3'b101, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(row(mk_mflo(5'd8),             1, 0, 5'd0, 0, 3'b000, (i < 3)));
        vecs.push_back(row(mk_mflo(5'd8),                 0, 1, 5'd8, 1, 3'b111, 0));
        // reset two cycles into a MULT, then MFLO issues at once
        vecs.push_back(row(mk_mult(5'd3, 5'd4),           0, 1, 5'd0, 0, 3'b101, 1));
        vecs.push_back(row(mk_nop(),                      0, 0, 5'd0, 0, 3'b000, 1));
        vecs.push_back(row(mk_nop(),                      0, 0, 5'd0, 0, 3'b000, 1));
        s = mk_mflo(5'd9); s.rst = 1;
        vecs.push_back(row(s,                             0, 0, 5'd0, 0, 3'b000, 0));
        vecs.push_back(row(mk_mflo(5'd9),                 0, 1, 5'd9, 1, 3'b111, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) run_cycle(vecs[i].s, 1'b1, vecs[i], i);

        // Randomized phase against the behavioural model. Small register
        // range makes dependencies frequent.
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst       = (i == 0) || ($urandom_range(0, 39) == 0);
            s.flush     = ($urandom_range(0, 7) == 0);
            s.valid     = ($urandom_range(0, 7) != 0);
            s.regwrite  = 1'($urandom_range(0, 1));
            s.memread   = ($urandom_range(0, 2) == 0);
            s.memwrite  = ($urandom_range(0, 5) == 0);
            s.wAddSel   = 2'($urandom_range(0, 3));
            s.wDataSel  = 2'($urandom_range(0, 3));
            s.func      = 3'($urandom_range(0, 7));
            s.bdsel     = 1'($urandom_range(0, 1));
            s.dsel      = 1'($urandom_range(0, 1));
            s.IDdatasel = 2'($urandom_range(0, 3));
            s.rs        = 5'($urandom_range(0, 3));
            s.rt        = 5'($urandom_range(0, 3));
            s.rd        = 5'($urandom_range(0, 3));
            s.uses_rs   = 1'($urandom_range(0, 1));
            s.uses_rt   = 1'($urandom_range(0, 1));
            run_cycle(s, 1'b0, dummy, i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
